// File: rtl/transpose_stream_ctrl_if.sv
// Element stream bundle for transpose_stream_ctrl.
//   in_valid/in_ready/in_data/in_last : row-major input element stream
//   out_valid/out_ready/out_data/out_last : row-major transposed output stream
//   frame_done : pulse on the final output handshake
//   err        : sticky in_last framing error
// slave = the transposer; master = the source/consumer side.
interface transpose_stream_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  frame_done;
  logic                  err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_done, err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_done, err
  );
endinterface

// File: rtl/transpose_stream_ctrl.sv
// Streaming matrix transposer: loads an MxN matrix row-major, then emits it
// column-major (the NxM transpose, row-major).
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   io_bus : element stream bundle (slave side), see transpose_stream_ctrl_if
module transpose_stream_ctrl #(
  parameter int unsigned M          = 2,
  parameter int unsigned N          = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  transpose_stream_ctrl_if.slave  io_bus
);

  localparam int unsigned MAX_DIM = (M > N) ? M : N;
  localparam int unsigned CW      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int unsigned RW      = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned CLW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(M - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);
  localparam bit            SINGLE   = (M == 1) && (N == 1);

  typedef enum logic {S_LOAD, S_DRAIN} state_t;

  state_t                r_state, w_state_n;
  logic [CW-1:0]         r_i, r_j, w_i_n, w_j_n, w_ni, w_nj;
  logic                  r_in_ready, w_in_ready_n;
  logic                  r_out_valid, w_out_valid_n;
  logic [DATA_WIDTH-1:0] r_out_data, w_out_data_n;
  logic                  r_out_last, w_out_last_n;
  logic                  r_err, w_err_n;
  logic                  w_wr_en;
  logic                  w_last_elem;
  logic                  w_in_fire, w_out_fire;
  logic [DATA_WIDTH-1:0] r_buf [M][N];

  assign w_in_fire  = r_in_ready & io_bus.in_valid;
  assign w_out_fire = r_out_valid & io_bus.out_ready;

  // Next-state: r_i/r_j are (row,col) in LOAD and (i,j) with i inner in DRAIN.
  always_comb begin
    w_state_n     = r_state;
    w_i_n         = r_i;
    w_j_n         = r_j;
    w_ni          = r_i;
    w_nj          = r_j;
    w_in_ready_n  = r_in_ready;
    w_out_valid_n = r_out_valid;
    w_out_data_n  = r_out_data;
    w_out_last_n  = r_out_last;
    w_err_n       = r_err;
    w_wr_en       = 1'b0;
    w_last_elem   = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        if (w_in_fire) begin
          w_wr_en     = 1'b1;
          w_last_elem = (r_i == LAST_ROW) && (r_j == LAST_COL);
          if (io_bus.in_last != w_last_elem) w_err_n = 1'b1;
          if (w_last_elem) begin
            w_state_n     = S_DRAIN;
            w_i_n         = '0;
            w_j_n         = '0;
            w_in_ready_n  = 1'b0;
            w_out_valid_n = 1'b1;
            w_out_last_n  = SINGLE;
            // For 1x1 the element being written is the first one emitted.
            w_out_data_n  = SINGLE ? io_bus.in_data : r_buf[RW'(0)][CLW'(0)];
          end else if (r_j == LAST_COL) begin
            w_j_n = '0;
            w_i_n = r_i + CW'(1);
          end else begin
            w_j_n = r_j + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (w_out_fire) begin
          if (r_out_last) begin
            w_state_n     = S_LOAD;
            w_i_n         = '0;
            w_j_n         = '0;
            w_in_ready_n  = 1'b1;
            w_out_valid_n = 1'b0;
            w_out_last_n  = 1'b0;
          end else begin
            if (r_i == LAST_ROW) begin
              w_ni = '0;
              w_nj = r_j + CW'(1);
            end else begin
              w_ni = r_i + CW'(1);
            end
            w_i_n        = w_ni;
            w_j_n        = w_nj;
            w_out_data_n = r_buf[RW'(w_ni)][CLW'(w_nj)];
            w_out_last_n = (w_ni == LAST_ROW) && (w_nj == LAST_COL);
          end
        end
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_i         <= '0;
      r_j         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_i         <= w_i_n;
      r_j         <= w_j_n;
      r_in_ready  <= w_in_ready_n;
      r_out_valid <= w_out_valid_n;
      r_out_data  <= w_out_data_n;
      r_out_last  <= w_out_last_n;
      r_err       <= w_err_n;
    end
  end

  // Matrix buffer, intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[RW'(r_i)][CLW'(r_j)] <= io_bus.in_data;
  end

  assign io_bus.in_ready   = r_in_ready;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.out_data   = r_out_data;
  assign io_bus.out_last   = r_out_last;
  assign io_bus.err        = r_err;
  // Marks the handshake itself, so it follows out_ready in the same cycle.
  assign io_bus.frame_done = r_out_valid & io_bus.out_ready & r_out_last;

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Bench for transpose_stream_ctrl: four instances (2x3, 2x2, 1x4, 1x1) share
// one stimulus/compare path selected by sel.
module tb_transpose_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;
  int         rdy_mode;
  int         cyc = 0;
  logic       chk_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: always ready, 1: ready one cycle in three, 2: never ready
  assign out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : 1'b0;

  logic [3:0] v_in_ready, v_out_valid, v_out_last, v_fd, v_err;
  logic [7:0] v_data [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned GM = (g < 2) ? 2 : 1;
    localparam int unsigned GN = (g == 0) ? 3 : (g == 1) ? 2 : (g == 2) ? 4 : 1;
    transpose_stream_ctrl_if #(.DATA_WIDTH(8)) bus ();
    assign bus.in_valid  = in_valid && (sel == 2'(g));
    assign bus.in_data   = in_data;
    assign bus.in_last   = in_last;
    assign bus.out_ready = out_ready && (sel == 2'(g));
    transpose_stream_ctrl #(.M(GM), .N(GN), .DATA_WIDTH(8)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
    );
    assign v_in_ready[g]  = bus.in_ready;
    assign v_out_valid[g] = bus.out_valid;
    assign v_out_last[g]  = bus.out_last;
    assign v_fd[g]        = bus.frame_done;
    assign v_err[g]       = bus.err;
    assign v_data[g]      = bus.out_data;
  end

  logic       m_in_ready, m_out_valid, m_out_last, m_fd, m_err;
  logic [7:0] m_out_data;
  assign m_in_ready  = v_in_ready[sel];
  assign m_out_valid = v_out_valid[sel];
  assign m_out_last  = v_out_last[sel];
  assign m_fd        = v_fd[sel];
  assign m_err       = v_err[sel];
  assign m_out_data  = v_data[sel];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Behavioural model: collect a whole matrix, then queue its transpose.
  typedef struct { logic [7:0] d; logic l; } exp_t;
  logic [7:0] acc [$];
  exp_t       exp_q [$];
  logic       exp_err [4];
  logic [7:0] got [$];
  int         fd_cnt = 0;

  function automatic void dims(input logic [1:0] s, output int m, output int n);
    case (s)
      2'd0:    begin m = 2; n = 3; end
      2'd1:    begin m = 2; n = 2; end
      2'd2:    begin m = 1; n = 4; end
      default: begin m = 1; n = 1; end
    endcase
  endfunction

  // Single compare process: check outputs, then advance the model to the next edge.
  always @(negedge clk) begin
    int   mm, nn;
    logic ev, full;
    exp_t e;
    ev = (exp_q.size() != 0);
    if (chk_en) begin
      check("in_ready", 32'(m_in_ready), 32'(!ev));
      check("out_valid", 32'(m_out_valid), 32'(ev));
      if (ev) begin
        check("out_data", 32'(m_out_data), 32'(exp_q[0].d));
        check("out_last", 32'(m_out_last), 32'(exp_q[0].l));
        check("frame_done", 32'(m_fd), 32'(out_ready && exp_q[0].l));
      end else begin
        check("frame_done_idle", 32'(m_fd), 32'(0));
      end
      check("err", 32'(m_err), 32'(exp_err[sel]));
      if (m_out_valid && out_ready) got.push_back(m_out_data);
      if (m_fd) fd_cnt++;
    end
    if (rst) begin
      acc.delete();
      exp_q.delete();
      for (int k = 0; k < 4; k++) exp_err[k] = 1'b0;
    end else begin
      dims(sel, mm, nn);
      if (!ev) begin
        if (in_valid) begin
          acc.push_back(in_data);
          full = (acc.size() == mm * nn);
          if (in_last != full) exp_err[sel] = 1'b1;
          if (full) begin
            for (int j = 0; j < nn; j++)
              for (int i = 0; i < mm; i++) begin
                e.d = acc[i * nn + j];
                e.l = (i == mm - 1) && (j == nn - 1);
                exp_q.push_back(e);
              end
            acc.delete();
          end
        end
      end else if (out_ready) begin
        e = exp_q.pop_front();
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic l);
    logic rd, ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int k = 0; k < 200; k++) begin
      rd = m_in_ready;
      @(posedge clk);
      #1;
      if (rd) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) fail_timeout("push");
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) fail_timeout("drain");
  endtask

  task automatic check_seq(input string name, input int exp_seq [$]);
    check({name, "_len"}, 32'(got.size()), 32'(exp_seq.size()));
    for (int k = 0; k < exp_seq.size() && k < got.size(); k++)
      check(name, 32'(got[k]), 32'(exp_seq[k]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eq [$];
    int fd0;
    rst = 1'b1; sel = 2'd0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    rdy_mode = 0; chk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("rst_in_ready", 32'(m_in_ready), 32'(1));
    check("rst_out_valid", 32'(m_out_valid), 32'(0));
    check("rst_out_last", 32'(m_out_last), 32'(0));
    check("rst_frame_done", 32'(m_fd), 32'(0));
    check("rst_err", 32'(m_err), 32'(0));

    // 1: 2x3 at full rate
    got.delete(); fd0 = fd_cnt;
    for (int k = 1; k <= 6; k++) push(8'(k), k == 6);
    check("t1_valid_after_last", 32'(m_out_valid), 32'(1));
    check("t1_first_data", 32'(m_out_data), 32'(1));
    wait_idle();
    eq = '{1, 4, 2, 5, 3, 6};
    check_seq("t1_seq", eq);
    check("t1_fd_count", 32'(fd_cnt - fd0), 32'(1));
    check("t1_err", 32'(m_err), 32'(0));

    // 2: input gaps and output backpressure
    idle(1);
    got.delete(); rdy_mode = 1;
    for (int k = 1; k <= 6; k++) begin
      push(8'(k), k == 6);
      if (k < 6) idle(k % 3);
    end
    check("t2_in_ready_drain", 32'(m_in_ready), 32'(0));
    wait_idle();
    eq = '{1, 4, 2, 5, 3, 6};
    check_seq("t2_seq", eq);
    rdy_mode = 0;
    idle(1);

    // 3: 2x2 with misplaced in_last
    sel = 2'd1; got.delete();
    push(8'd1, 1'b0);
    check("t3_err_first", 32'(m_err), 32'(0));
    push(8'd2, 1'b1);
    check("t3_err_set", 32'(m_err), 32'(1));
    push(8'd3, 1'b0);
    push(8'd4, 1'b0);
    wait_idle();
    eq = '{1, 3, 2, 4};
    check_seq("t3_seq", eq);
    check("t3_err_sticky", 32'(m_err), 32'(1));
    idle(1);

    // 4: reset mid-LOAD and mid-DRAIN
    sel = 2'd0;
    push(8'd1, 1'b0); push(8'd2, 1'b0); push(8'd3, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t4_rst_load_in_ready", 32'(m_in_ready), 32'(1));
    check("t4_rst_load_out_valid", 32'(m_out_valid), 32'(0));
    rdy_mode = 2;
    for (int k = 0; k < 6; k++) push(8'(20 + k), k == 5);
    rdy_mode = 0;
    idle(2);
    rdy_mode = 2; rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t4_rst_drain_in_ready", 32'(m_in_ready), 32'(1));
    check("t4_rst_drain_out_valid", 32'(m_out_valid), 32'(0));
    rdy_mode = 0; got.delete();
    for (int k = 0; k < 6; k++) push(8'(10 + k), k == 5);
    wait_idle();
    eq = '{10, 13, 11, 14, 12, 15};
    check_seq("t4_seq", eq);
    idle(1);

    // 5: three matrices back-to-back
    got.delete(); fd0 = fd_cnt;
    for (int k = 0; k < 18; k++) push(8'(30 + k), (k % 6) == 5);
    wait_idle();
    eq = '{30, 33, 31, 34, 32, 35, 36, 39, 37, 40, 38, 41, 42, 45, 43, 46, 44, 47};
    check_seq("t5_seq", eq);
    check("t5_fd_count", 32'(fd_cnt - fd0), 32'(3));
    check("t5_err", 32'(m_err), 32'(0));
    idle(1);

    // 6: degenerate 1x4 and 1x1
    sel = 2'd2; got.delete();
    for (int k = 0; k < 4; k++) push(8'(7 + k), k == 3);
    wait_idle();
    eq = '{7, 8, 9, 10};
    check_seq("t6_1x4_seq", eq);
    idle(1);
    sel = 2'd3; got.delete(); fd0 = fd_cnt;
    push(8'd42, 1'b1);
    check("t6_1x1_valid", 32'(m_out_valid), 32'(1));
    check("t6_1x1_data", 32'(m_out_data), 32'(42));
    check("t6_1x1_last", 32'(m_out_last), 32'(1));
    wait_idle();
    eq = '{42};
    check_seq("t6_1x1_seq", eq);
    check("t6_1x1_fd", 32'(fd_cnt - fd0), 32'(1));
    check("t6_1x1_err", 32'(m_err), 32'(0));
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
